sram_ctrl: RTL and testbench
============================

Name: sram_ctrl

Overview:
- Clocked SRAM access sequencer that sits directly downstream of the cartridge bank mapper.
- Takes the mapper's `sram_enabled`/`sram_writable` register bits plus the raw Mega Drive cartridge bus strobes, and decides when a cycle targets battery-backed SRAM.
- Generates properly timed `sram_ce`/`sram_oe`/`sram_we` and the address/data to the SRAM device.
- Gives the mapper a select flag (`sram_sel`) so the mapper steers `cart_data` from SRAM instead of ROM.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of each bus-strobe synchronizer (minimum 2).
- ADDR_W, 15, SRAM word address width (32K x 8).
- WE_CYCLES, 4, clk cycles `sram_we` stays low per write (minimum 1).
- REC_CYCLES, 2, clk cycles of write recovery with `sram_ce` high before the next access (minimum 1).

Ports:
- clk  in  1  system clock (nominal 50 MHz, asynchronous to the cartridge bus).
- vres  in  1  asynchronous active-low reset.
- cart_address  in  23  cartridge bus address [23:1].
- cart_wdata  in  8  cartridge bus data lower byte [7:0] (odd-byte SRAM).
- ce_0  in  1  cartridge chip enable, active low.
- cas0  in  1  read/write strobe for $000000-$DFFFFF, active low.
- lwr  in  1  lower-byte write strobe, active low.
- sram_enabled  in  1  from mapper; SRAM window mapped when 1.
- sram_writable  in  1  from mapper; writes allowed when 1.
- dirty_clr  in  1  synchronous pulse; clears `sram_dirty`.
- sram_address  out  ADDR_W  SRAM address.
- sram_wdata  out  8  SRAM write data.
- sram_wdata_oe  out  1  drive `sram_wdata` onto the SRAM data pins.
- sram_ce  out  1  SRAM chip enable, active low.
- sram_oe  out  1  SRAM output enable, active low.
- sram_we  out  1  SRAM write enable, active low.
- sram_sel  out  1  to mapper; 1 = current read cycle is served by SRAM.
- sram_dirty  out  1  set by any completed SRAM write (battery-save indicator).

Behaviour:
- **Reset.** `vres` low immediately forces the following, regardless of state, including mid-write:
  - `sram_ce`=`sram_oe`=`sram_we`=1.
  - `sram_sel`=0, `sram_wdata_oe`=0, `sram_dirty`=0.
  - `sram_address`=0, `sram_wdata`=0.
  - FSM to IDLE, counters to 0, synchronizers to 1 (inactive).
- **Synchronization.** `ce_0`, `cas0` and `lwr` each pass through SYNC_STAGES flops. `lwr` also gets a falling-edge detect on the synced value. `cart_address` and `cart_wdata` are sampled unsynchronized only on the edge-detect cycle; they are stable while `lwr` is low.
- **Window hit.**
  - hit = synced `ce_0`==0 and `cart_address[21]`==1 ($200000-$3FFFFF) and `sram_enabled`==1.
  - SRAM word address = `cart_address[ADDR_W:1]`.
- **FSM states:** IDLE, READ, WR_PULSE, WR_RECOVER.
- **IDLE:**
  - Write trigger takes priority: lwr falling edge and hit and synced `cas0`==0 and `sram_writable`==1.
    - Latch address and data.
    - Set `sram_wdata_oe`=1, `sram_ce`=0; `sram_we`=0 on the next clock.
    - Load the counter with WE_CYCLES and go to WR_PULSE.
  - Write with `sram_writable`==0: ignored; stay IDLE; `sram_dirty` unchanged.
  - Read trigger: hit and synced `cas0`==0 and synced `lwr`==1.
    - Load address; `sram_ce`=0, `sram_oe`=0, `sram_sel`=1 from the next clock.
    - Go to READ.
- **READ:**
  - Hold outputs while hit and synced `cas0`==0.
  - When either deasserts: `sram_ce`=`sram_oe`=1 and `sram_sel`=0 on the next clock; go to IDLE.
  - If `sram_enabled` drops mid-read, hit drops and the read ends the same way.
  - An lwr falling edge seen in READ terminates the read (`sram_oe`=1) and enters the write path on the next clock.
- **WR_PULSE:**
  - `sram_we` low for exactly WE_CYCLES clocks; address and data held constant.
  - At expiry: `sram_we`=1, `sram_dirty`=1, counter loads REC_CYCLES, go to WR_RECOVER.
- **WR_RECOVER:**
  - `sram_ce`=1 and `sram_wdata_oe`=0 for REC_CYCLES clocks, then IDLE.
  - Bus strobes arriving during a write or recovery are not lost: after IDLE is reached, a still-active read is served normally. Only a new lwr falling edge creates a write; a second edge during WR_PULSE/WR_RECOVER is dropped.
- **Latency:** pin change to SRAM strobe is SYNC_STAGES+1 clocks; at 50 MHz this is 60 ns, within the 7.67 MHz bus cycle.
- **Dirty flag:** `dirty_clr` and a write completion in the same cycle leave `sram_dirty`=1 (set wins).
- **Outputs:** all are registered; no combinational path from bus pins to SRAM strobes.
- **Widths:** counters are clog2(max(WE_CYCLES,REC_CYCLES)+1) bits and decrement to 0 without wrap.

Decomposition:
- Shared package `mapper_pkg`:
  - FSM state enum.
  - SRAM window constant (address bit 21).
  - `mapper_reg_addr` 5'b01111 and SRAM control bit indices (enable bit 0, writable bit 1), shared with the mapper.
- One sub-module, `bus_sync`: parameterised SYNC_STAGES synchronizer with reset-to-1 and a registered falling-edge output. It is instantiated for `ce_0`, `cas0` and `lwr`.

Test Plan:
- Reset value check: hold `vres` low 5 clocks -> `sram_ce`/`oe`/`we`=1, `sram_sel`=0, `sram_dirty`=0, `sram_address`=0.
- Write to $200001 with data 8'hA5, enabled=1, writable=1 -> `sram_address`=0, `sram_wdata`=A5, `sram_we` low exactly 4 clocks, then `sram_ce` high 2 clocks, `sram_dirty`=1.
- Read at $200003 with enabled=1 -> `sram_sel`=1, `sram_ce`=`sram_oe`=0 starting 3 clocks after `cas0` falls; both return to 1 one clock after synced `cas0` rises.
- Same read with enabled=0, or at $100001 -> `sram_sel` stays 0 and no SRAM strobe toggles.
- Write with writable=0 -> `sram_we` never low, `sram_dirty` stays 0; a following write with writable=1 works normally.
- Assert `vres` low during the 2nd clock of WR_PULSE -> `sram_we`=1 and `sram_ce`=1 immediately, `sram_dirty`=0, FSM in IDLE after release; `dirty_clr` coincident with write completion leaves `sram_dirty`=1.

Source files
------------

// File: rtl/mapper_pkg.sv
// rtl/mapper_pkg.sv - shared mapper/SRAM definitions: FSM states, window bit, register map
package mapper_pkg;

    // SRAM access sequencer states
    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_READ       = 2'd1,
        ST_WR_PULSE   = 2'd2,
        ST_WR_RECOVER = 2'd3
    } sram_state_t;

    // Byte address bit that selects the $200000-$3FFFFF SRAM window
    localparam int SRAM_WIN_BIT = 21;

    // Mapper register holding the SRAM control bits, and their positions
    localparam logic [4:0] mapper_reg_addr = 5'b01111;
    localparam int SRAM_EN_BIT = 0;
    localparam int SRAM_WR_BIT = 1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bus_sync.sv
// rtl/bus_sync.sv - reset-to-1 strobe synchronizer with registered falling-edge flag
module bus_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic fall
);

    logic [STAGES-1:0] chain;

    assign q = chain[STAGES-1];

    // Shift the raw strobe through the chain; fall is high on the first cycle q reads 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '1;
            fall  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
            fall  <= chain[STAGES-1] & ~chain[STAGES-2];
        end
    end

endmodule

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - battery-backed SRAM access sequencer behind the cartridge mapper
module sram_ctrl
    import mapper_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 15,
    parameter int WE_CYCLES   = 4,
    parameter int REC_CYCLES  = 2
) (
    input  logic              clk,
    input  logic              vres,
    input  logic [23:1]       cart_address,
    input  logic [7:0]        cart_wdata,
    input  logic              ce_0,
    input  logic              cas0,
    input  logic              lwr,
    input  logic              sram_enabled,
    input  logic              sram_writable,
    input  logic              dirty_clr,
    output logic [ADDR_W-1:0] sram_address,
    output logic [7:0]        sram_wdata,
    output logic              sram_wdata_oe,
    output logic              sram_ce,
    output logic              sram_oe,
    output logic              sram_we,
    output logic              sram_sel,
    output logic              sram_dirty
);

    localparam int CNT_MAX = max_int(WE_CYCLES, REC_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Synchronized bus strobes (all active low)
    logic ce_s, cas_s, lwr_s, lwr_fall;
    logic unused_ce_fall, unused_cas_fall, unused_addr_bits;

    bus_sync #(.STAGES(SYNC_STAGES)) u_sync_ce (
        .clk(clk), .rst_n(vres), .d(ce_0), .q(ce_s), .fall(unused_ce_fall)
    );
    bus_sync #(.STAGES(SYNC_STAGES)) u_sync_cas (
        .clk(clk), .rst_n(vres), .d(cas0), .q(cas_s), .fall(unused_cas_fall)
    );
    bus_sync #(.STAGES(SYNC_STAGES)) u_sync_lwr (
        .clk(clk), .rst_n(vres), .d(lwr), .q(lwr_s), .fall(lwr_fall)
    );

    // Address bits outside the window decode and word address are don't-care here
    assign unused_addr_bits = ^cart_address;

    sram_state_t       state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [ADDR_W-1:0] addr_n;
    logic [7:0]        wdata_n;
    logic              wdata_oe_n, ce_n, oe_n, we_n, sel_n, dirty_set;
    logic              hit, bus_active, start_write, start_read;

    // Decode the synced strobes and compute next state plus next registered pin values
    always_comb begin
        hit         = ~ce_s & cart_address[SRAM_WIN_BIT] & sram_enabled;
        bus_active  = hit & ~cas_s;
        start_write = lwr_fall & bus_active & sram_writable;
        start_read  = bus_active & lwr_s;

        state_n    = state;
        cnt_n      = cnt;
        addr_n     = sram_address;
        wdata_n    = sram_wdata;
        wdata_oe_n = sram_wdata_oe;
        ce_n       = sram_ce;
        oe_n       = sram_oe;
        we_n       = sram_we;
        sel_n      = sram_sel;
        dirty_set  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start_write) begin
                    addr_n     = cart_address[ADDR_W:1];
                    wdata_n    = cart_wdata;
                    wdata_oe_n = 1'b1;
                    ce_n       = 1'b0;
                    cnt_n      = CNT_W'(WE_CYCLES);
                    state_n    = ST_WR_PULSE;
                end else if (start_read) begin
                    addr_n  = cart_address[ADDR_W:1];
                    ce_n    = 1'b0;
                    oe_n    = 1'b0;
                    sel_n   = 1'b1;
                    state_n = ST_READ;
                end
            end

            ST_READ: begin
                if (lwr_fall) begin
                    // A write strobe cuts the read short; the SRAM output is released first
                    oe_n  = 1'b1;
                    sel_n = 1'b0;
                    if (start_write) begin
                        addr_n     = cart_address[ADDR_W:1];
                        wdata_n    = cart_wdata;
                        wdata_oe_n = 1'b1;
                        cnt_n      = CNT_W'(WE_CYCLES);
                        state_n    = ST_WR_PULSE;
                    end else begin
                        ce_n    = 1'b1;
                        state_n = ST_IDLE;
                    end
                end else if (!bus_active) begin
                    ce_n    = 1'b1;
                    oe_n    = 1'b1;
                    sel_n   = 1'b0;
                    state_n = ST_IDLE;
                end
            end

            ST_WR_PULSE: begin
                // cnt counts the remaining low clocks of sram_we; first clock here is setup
                if (cnt != '0) begin
                    we_n  = 1'b0;
                    cnt_n = cnt - CNT_W'(1);
                end else begin
                    we_n       = 1'b1;
                    ce_n       = 1'b1;
                    wdata_oe_n = 1'b0;
                    dirty_set  = 1'b1;
                    cnt_n      = CNT_W'(REC_CYCLES);
                    state_n    = ST_WR_RECOVER;
                end
            end

            ST_WR_RECOVER: begin
                // On the last recovery clock a pending read may start so ce is high exactly REC_CYCLES
                if (cnt > CNT_W'(1)) begin
                    cnt_n = cnt - CNT_W'(1);
                end else begin
                    cnt_n = '0;
                    if (start_read) begin
                        addr_n  = cart_address[ADDR_W:1];
                        ce_n    = 1'b0;
                        oe_n    = 1'b0;
                        sel_n   = 1'b1;
                        state_n = ST_READ;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end

            default: begin
                state_n    = ST_IDLE;
                ce_n       = 1'b1;
                oe_n       = 1'b1;
                we_n       = 1'b1;
                sel_n      = 1'b0;
                wdata_oe_n = 1'b0;
                cnt_n      = '0;
            end
        endcase
    end

    // State, counter and all SRAM-facing pins are registered
    always_ff @(posedge clk or negedge vres) begin
        if (!vres) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            sram_address  <= '0;
            sram_wdata    <= '0;
            sram_wdata_oe <= 1'b0;
            sram_ce       <= 1'b1;
            sram_oe       <= 1'b1;
            sram_we       <= 1'b1;
            sram_sel      <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            sram_address  <= addr_n;
            sram_wdata    <= wdata_n;
            sram_wdata_oe <= wdata_oe_n;
            sram_ce       <= ce_n;
            sram_oe       <= oe_n;
            sram_we       <= we_n;
            sram_sel      <= sel_n;
        end
    end

    // Battery-save flag: a completing write wins over a coincident clear
    always_ff @(posedge clk or negedge vres) begin
        if (!vres) begin
            sram_dirty <= 1'b0;
        end else if (dirty_set) begin
            sram_dirty <= 1'b1;
        end else if (dirty_clr) begin
            sram_dirty <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// tb/tb_sram_ctrl.sv - scoreboard bench for sram_ctrl
module tb_sram_ctrl;

    localparam int ADDR_W    = 15;
    localparam int WE_CYCLES = 4;

    logic              clk = 1'b0;
    logic              vres = 1'b0;
    logic [23:1]       cart_address = '0;
    logic [7:0]        cart_wdata = '0;
    logic              ce_0 = 1'b1, cas0 = 1'b1, lwr = 1'b1;
    logic              sram_enabled = 1'b1, sram_writable = 1'b1, dirty_clr = 1'b0;
    logic [ADDR_W-1:0] sram_address;
    logic [7:0]        sram_wdata;
    logic              sram_wdata_oe, sram_ce, sram_oe, sram_we, sram_sel, sram_dirty;

    sram_ctrl #(.SYNC_STAGES(2), .ADDR_W(ADDR_W), .WE_CYCLES(WE_CYCLES), .REC_CYCLES(2)) dut (
        .clk(clk), .vres(vres), .cart_address(cart_address), .cart_wdata(cart_wdata),
        .ce_0(ce_0), .cas0(cas0), .lwr(lwr), .sram_enabled(sram_enabled),
        .sram_writable(sram_writable), .dirty_clr(dirty_clr), .sram_address(sram_address),
        .sram_wdata(sram_wdata), .sram_wdata_oe(sram_wdata_oe), .sram_ce(sram_ce),
        .sram_oe(sram_oe), .sram_we(sram_we), .sram_sel(sram_sel), .sram_dirty(sram_dirty)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit wr;
        int addr;
        int data;
        int len;   // write: we-low clocks; read: strobe latency from cas0 fall (-1 = any)
        int gap;   // read: ce-high clocks before this read (-1 = any)
        int ext;   // read: clocks from cas0 rise to strobes released
    } exp_t;

    exp_t q[$];
    int n_vec = 0, n_miss = 0;
    int t_cas_fall = 0, t_cas_rise = 0;
    int we_falls = 0, ce_falls = 0, sel_rises = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: reconstructs each write and read from the pins and compares with the queue
    initial begin
        bit prev_we = 1, prev_ce = 1, prev_sel = 0, w_bad = 0, r_bad = 0;
        int we_run = 0, ce_run = 0, last_gap = 0, w_addr = 0, w_data = 0;
        int r_addr = 0, r_lat = 0, r_gap = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!vres) begin
                prev_we = 1; prev_ce = 1; prev_sel = 0; we_run = 0; ce_run = 0;
            end else begin
                if (sram_ce) ce_run++;
                else if (prev_ce) begin ce_falls++; last_gap = ce_run; ce_run = 0; end

                if (!sram_we) begin
                    if (prev_we) begin
                        we_falls++; we_run = 0; w_bad = 0;
                        w_addr = int'(sram_address); w_data = int'(sram_wdata);
                    end
                    we_run++;
                    if (int'(sram_address) != w_addr || int'(sram_wdata) != w_data ||
                        !sram_wdata_oe || sram_ce) w_bad = 1;
                end else if (!prev_we) begin
                    if (q.size() == 0) check("unexpected_write", 1, 0);
                    else begin
                        e = q.pop_front();
                        check("wr_kind", 1, int'(e.wr));
                        check("wr_addr", w_addr, e.addr);
                        check("wr_data", w_data, e.data);
                        check("wr_we_len", we_run, e.len);
                        check("wr_hold", int'(w_bad), 0);
                        check("wr_dirty", int'(sram_dirty), 1);
                    end
                end

                if (sram_sel && !prev_sel) begin
                    sel_rises++;
                    r_addr = int'(sram_address); r_lat = cyc - t_cas_fall; r_gap = last_gap;
                    r_bad = 0;
                end
                if (sram_sel && (sram_ce || sram_oe || int'(sram_address) != r_addr)) r_bad = 1;
                if (!sram_sel && prev_sel) begin
                    if (!sram_ce || !sram_oe) r_bad = 1;
                    if (q.size() == 0) check("unexpected_read", 1, 0);
                    else begin
                        e = q.pop_front();
                        check("rd_kind", 0, int'(e.wr));
                        check("rd_addr", r_addr, e.addr);
                        if (e.len >= 0) check("rd_latency", r_lat, e.len);
                        if (e.gap >= 0) check("rd_ce_gap", r_gap, e.gap);
                        check("rd_release", cyc - t_cas_rise, e.ext);
                        check("rd_strobes", int'(r_bad), 0);
                    end
                end
                prev_we = sram_we; prev_ce = sram_ce; prev_sel = sram_sel;
            end
        end
    end

    task automatic start_bus(input logic [23:0] a, input logic [7:0] d, input logic wr);
        @(negedge clk);
        cart_address = a[23:1];
        cart_wdata = d;
        ce_0 = 1'b0; cas0 = 1'b0; lwr = ~wr;
        t_cas_fall = cyc;
    endtask

    task automatic end_bus();
        ce_0 = 1'b1; cas0 = 1'b1; lwr = 1'b1;
        t_cas_rise = cyc;
    endtask

    task automatic bus_cycle(input logic [23:0] a, input logic [7:0] d, input logic wr, input int hold);
        start_bus(a, d, wr);
        repeat (hold) @(negedge clk);
        end_bus();
        repeat (6) @(negedge clk);
    endtask

    task automatic wait_we_low(output bit ok);
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (!sram_we) ok = 1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        int snap_we, snap_ce, snap_sel;
        bit ok;

        // Reset held 5 clocks
        repeat (5) @(negedge clk);
        check("rst_ce", int'(sram_ce), 1);
        check("rst_oe", int'(sram_oe), 1);
        check("rst_we", int'(sram_we), 1);
        check("rst_sel", int'(sram_sel), 0);
        check("rst_dirty", int'(sram_dirty), 0);
        check("rst_addr", int'(sram_address), 0);
        check("rst_wdata_oe", int'(sram_wdata_oe), 0);
        vres = 1'b1;
        repeat (3) @(negedge clk);

        // Write while not writable is ignored
        sram_writable = 1'b0;
        snap_we = we_falls;
        bus_cycle(24'h200001, 8'hA5, 1'b1, 14);
        check("ro_no_we", we_falls, snap_we);
        check("ro_dirty", int'(sram_dirty), 0);
        sram_writable = 1'b1;

        // Normal write at $200001
        q.push_back('{1, 0, 8'hA5, 4, -1, -1});
        bus_cycle(24'h200001, 8'hA5, 1'b1, 14);

        // Read at $200003
        q.push_back('{0, 1, 0, 3, -1, 3});
        bus_cycle(24'h200003, 8'h00, 1'b0, 8);

        // Read with window unmapped, then outside the window
        snap_ce = ce_falls; snap_sel = sel_rises;
        sram_enabled = 1'b0;
        bus_cycle(24'h200003, 8'h00, 1'b0, 8);
        sram_enabled = 1'b1;
        bus_cycle(24'h100001, 8'h00, 1'b0, 8);
        check("miss_sel", sel_rises, snap_sel);
        check("miss_ce", ce_falls, snap_ce);

        // Write at top of SRAM with a read held active: read follows the recovery
        q.push_back('{1, 15'h3FFF, 8'h3C, 4, -1, -1});
        q.push_back('{0, 15'h3FFF, 0, 10, 2, 3});
        start_bus(24'h207FFF, 8'h3C, 1'b1);
        repeat (3) @(negedge clk);
        lwr = 1'b1;
        repeat (17) @(negedge clk);
        end_bus();
        repeat (8) @(negedge clk);

        // Standalone clear
        dirty_clr = 1'b1;
        @(negedge clk);
        dirty_clr = 1'b0;
        @(negedge clk);
        check("clr_dirty", int'(sram_dirty), 0);

        // Clear coincident with write completion
        q.push_back('{1, 8, 8'h5A, 4, -1, -1});
        start_bus(24'h200011, 8'h5A, 1'b1);
        wait_we_low(ok);
        check("clr_we_seen", int'(ok), 1);
        repeat (WE_CYCLES - 1) @(negedge clk);
        dirty_clr = 1'b1;
        @(negedge clk);
        dirty_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("set_wins_dirty", int'(sram_dirty), 1);
        end_bus();
        repeat (6) @(negedge clk);

        // Reset during the second clock of the write pulse
        start_bus(24'h200021, 8'h77, 1'b1);
        wait_we_low(ok);
        check("abort_we_seen", int'(ok), 1);
        vres = 1'b0;
        #1;
        check("abort_we", int'(sram_we), 1);
        check("abort_ce", int'(sram_ce), 1);
        check("abort_dirty", int'(sram_dirty), 0);
        check("abort_wdata_oe", int'(sram_wdata_oe), 0);
        repeat (5) @(negedge clk);
        end_bus();
        @(negedge clk);
        vres = 1'b1;
        repeat (4) @(negedge clk);

        // Controller is idle again: a plain read is served
        q.push_back('{0, 2, 0, 3, -1, 3});
        bus_cycle(24'h200005, 8'h00, 1'b0, 8);

        for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
        check("queue_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
